// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one outstanding fetch at a time
// over a req/ack handshake, and hands each fetched word to decode. It supports
// decode back-pressure, branch/jump redirect and a sticky misaligned-target fault.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        Mem_Req_o,
    output logic [31:0] Mem_Addr_o,
    input  logic        Mem_Ack_i,
    input  logic [31:0] Mem_Data_i,
    input  logic        Stall_i,
    input  logic        Redirect_i,
    input  logic [31:0] Redirect_PC_i,
    output logic [31:0] Instr_o,
    output logic [31:0] Instr_PC_o,
    output logic        Instr_Valid_o,
    output logic [6:0]  OP_o,
    output logic        Fault_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;        // next address to fetch (redirect target once redirected)
    logic [31:0] r_addr;      // address of the request on the bus; only moves between requests
    logic        r_discard;   // in-flight request belongs to a superseded path
    logic        r_req;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_valid;
    logic        r_fault;

    logic        w_ack;
    logic        w_redir_ok;
    logic        w_redir_bad;
    logic [31:0] w_pc_next;

    // An ack only counts while a request is actually being presented.
    assign w_ack       = Mem_Ack_i & r_req;
    assign w_redir_ok  = Redirect_i & (Redirect_PC_i[1:0] == 2'b00);
    assign w_redir_bad = Redirect_i & (Redirect_PC_i[1:0] != 2'b00);
    assign w_pc_next   = r_pc + 32'd4;

    assign Mem_Req_o     = r_req;
    assign Mem_Addr_o    = r_addr;
    assign Instr_o       = r_instr;
    assign Instr_PC_o    = r_instr_pc;
    assign Instr_Valid_o = r_valid;
    assign OP_o          = r_instr[6:0];
    assign Fault_o       = r_fault;

    // Fetch FSM with all outputs registered; reset overrides every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_discard  <= 1'b0;
            r_req      <= 1'b0;
            r_instr    <= NOP;
            r_instr_pc <= 32'h0000_0000;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_redir_bad) begin
                        // Abandon whatever is in flight; memory must tolerate the dropped request.
                        r_state   <= S_FAULT;
                        r_req     <= 1'b0;
                        r_fault   <= 1'b0 | 1'b1;
                        r_discard <= 1'b0;
                    end else if (w_redir_ok) begin
                        r_pc  <= Redirect_PC_i;
                        r_req <= 1'b1;
                        if (!r_req || w_ack) begin
                            // Nothing pending on the bus (or it completes now and is dropped):
                            // the target request can go out next cycle.
                            r_addr    <= Redirect_PC_i;
                            r_discard <= 1'b0;
                        end else begin
                            // Keep the bus address stable until the stale request is acked.
                            r_discard <= 1'b1;
                        end
                    end else if (w_ack && r_discard) begin
                        r_discard <= 1'b0;
                        r_addr    <= r_pc;
                        r_req     <= 1'b1;
                    end else if (w_ack) begin
                        r_instr    <= Mem_Data_i;
                        r_instr_pc <= r_pc;
                        r_pc       <= w_pc_next;
                        r_addr     <= w_pc_next;
                        r_valid    <= 1'b1;
                        r_req      <= 1'b0;
                        r_state    <= S_VALID;
                    end else begin
                        r_req <= 1'b1;
                    end
                end

                S_VALID: begin
                    if (w_redir_bad) begin
                        r_state <= S_FAULT;
                        r_valid <= 1'b0;
                        r_fault <= 1'b1;
                    end else if (w_redir_ok) begin
                        // Redirect wins over both stall and consume.
                        r_pc    <= Redirect_PC_i;
                        r_addr  <= Redirect_PC_i;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end else if (!Stall_i) begin
                        r_addr  <= r_pc;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end

                S_FAULT: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_fault <= 1'b1;
                end

                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus
// randomized memory latency, stall and redirect, checked cycle by cycle against
// a behavioural model and a program-order scoreboard.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        Mem_Req_o;
    logic [31:0] Mem_Addr_o;
    logic        ack;
    logic [31:0] dat;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] Instr_o;
    logic [31:0] Instr_PC_o;
    logic        Instr_Valid_o;
    logic [6:0]  OP_o;
    logic        Fault_o;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset         (rst),
        .Mem_Req_o     (Mem_Req_o),
        .Mem_Addr_o    (Mem_Addr_o),
        .Mem_Ack_i     (ack),
        .Mem_Data_i    (dat),
        .Stall_i       (stall),
        .Redirect_i    (redir),
        .Redirect_PC_i (rpc),
        .Instr_o       (Instr_o),
        .Instr_PC_o    (Instr_PC_o),
        .Instr_Valid_o (Instr_Valid_o),
        .OP_o          (OP_o),
        .Fault_o       (Fault_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs and the model's view of the fetch stream.
    logic        e_req, e_valid, e_fault;
    logic [31:0] e_addr, e_instr, e_ipc;
    logic [31:0] m_pc;      // next PC in program order
    logic        m_drop;    // word in flight belongs to an abandoned path
    logic [31:0] sb_next;   // PC the next delivered instruction must carry
    logic        prev_valid = 1'b0;

    // Stimulus knobs and memory responder state.
    int g_wait = 0;          // <0: random 0..3 wait cycles
    int g_stall_pct = 0;     // >0: random stall, else stall is left as set
    int g_redir_pct = 0;
    int g_mis_pct = 0;
    bit busy = 1'b0;
    int cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memfun(input logic [31:0] a);
        if (a == RESET_PC)         return 32'h0050_0093;
        if (a == RESET_PC + 32'd4) return 32'h00A0_0113;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Advance the reference by one clock using the inputs present at that edge.
    task automatic model_step();
        logic got;
        if (rst) begin
            e_req = 1'b0; e_addr = RESET_PC; e_instr = NOP; e_ipc = 32'd0;
            e_valid = 1'b0; e_fault = 1'b0; m_pc = RESET_PC; m_drop = 1'b0;
            sb_next = RESET_PC;
            return;
        end
        if (e_fault) return;
        if (redir && rpc[1:0] != 2'b00) begin
            e_fault = 1'b1; e_req = 1'b0; e_valid = 1'b0;
            return;
        end
        if (redir) sb_next = rpc;
        if (e_valid) begin
            if (redir) begin
                m_pc = rpc; e_addr = rpc; e_valid = 1'b0; e_req = 1'b1;
            end else if (!stall) begin
                e_addr = m_pc; e_valid = 1'b0; e_req = 1'b1;
            end
        end else begin
            got = ack && e_req;
            if (redir) begin
                m_pc = rpc;
                if (got || !e_req) begin e_addr = rpc; m_drop = 1'b0; end
                else m_drop = 1'b1;
            end else if (got && m_drop) begin
                m_drop = 1'b0; e_addr = m_pc;
            end else if (got) begin
                e_instr = dat; e_ipc = e_addr; m_pc = e_addr + 32'd4;
                e_valid = 1'b1; e_req = 1'b0;
                return;
            end
            e_req = 1'b1;
        end
    endtask

    // One clock: step model, compare, then choose the next cycle's inputs.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("req", 32'(Mem_Req_o), 32'(e_req));
        if (e_req) chk("addr", Mem_Addr_o, e_addr);
        chk("valid", 32'(Instr_Valid_o), 32'(e_valid));
        chk("instr", Instr_o, e_instr);
        chk("instr_pc", Instr_PC_o, e_ipc);
        chk("op", 32'(OP_o), 32'(e_instr[6:0]));
        chk("fault", 32'(Fault_o), 32'(e_fault));
        if (Instr_Valid_o && !prev_valid) begin
            chk("sb_pc", Instr_PC_o, sb_next);
            chk("sb_data", Instr_o, memfun(Instr_PC_o));
            sb_next = Instr_PC_o + 32'd4;
        end
        prev_valid = Instr_Valid_o;

        if (ack) begin ack = 1'b0; busy = 1'b0; end
        if (rst || !Mem_Req_o) begin
            busy = 1'b0;
        end else begin
            if (!busy) begin
                busy = 1'b1;
                cnt = (g_wait < 0) ? int'($urandom_range(3, 0)) : g_wait;
            end
            if (cnt == 0) begin ack = 1'b1; dat = memfun(Mem_Addr_o); end
            else cnt--;
        end

        redir = 1'b0;
        if (g_redir_pct > 0 && int'($urandom_range(99, 0)) < g_redir_pct) begin
            redir = 1'b1;
            rpc = RESET_PC + (32'($urandom_range(255, 0)) << 2);
            if (int'($urandom_range(99, 0)) < g_mis_pct) rpc[1:0] = 2'($urandom_range(3, 1));
        end
        if (g_stall_pct > 0) stall = (int'($urandom_range(99, 0)) < g_stall_pct);
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!Instr_Valid_o && n < max) begin tick(); n++; end
        chk("wait_valid", 32'(Instr_Valid_o), 32'd1);
    endtask

    initial begin
        rst = 1'b1; ack = 1'b0; dat = 32'd0; stall = 1'b0; redir = 1'b0; rpc = 32'd0;
        tick(); tick();
        chk("rst_req", 32'(Mem_Req_o), 32'd0);
        chk("rst_addr", Mem_Addr_o, RESET_PC);
        chk("rst_instr", Instr_o, NOP);
        chk("rst_op", 32'(OP_o), 32'h13);

        // Zero-wait fetch of the first two words.
        rst = 1'b0; g_wait = 0;
        tick();
        chk("zw_addr0", Mem_Addr_o, RESET_PC);
        tick();
        chk("zw_instr0", Instr_o, 32'h0050_0093);
        tick();
        chk("zw_addr1", Mem_Addr_o, 32'h0040_0004);
        tick();
        chk("zw_instr1", Instr_o, 32'h00A0_0113);
        chk("zw_op1", 32'(OP_o), 32'h13);
        repeat (6) tick();

        // Three wait states.
        g_wait = 3;
        repeat (20) tick();

        // Stall for five cycles while holding a word.
        g_wait = 1;
        wait_valid(20);
        stall = 1'b1;
        repeat (5) tick();
        g_wait = 2;
        stall = 1'b0;
        tick();
        chk("stall_rel_req", 32'(Mem_Req_o), 32'd1);

        // Redirect while a 2-wait request is pending.
        redir = 1'b1; rpc = 32'h0040_0100;
        tick();
        wait_valid(20);
        chk("redir_pc", Instr_PC_o, 32'h0040_0100);

        // Redirect in the same cycle as the ack.
        g_wait = 0;
        tick();
        redir = 1'b1; rpc = 32'h0040_0200;
        tick();
        wait_valid(10);
        chk("redir_ack_pc", Instr_PC_o, 32'h0040_0200);

        // PC wrap at the top of the address space.
        redir = 1'b1; rpc = 32'hFFFF_FFFC;
        tick();
        chk("wrap_req_addr", Mem_Addr_o, 32'hFFFF_FFFC);
        wait_valid(10);
        chk("wrap_ipc", Instr_PC_o, 32'hFFFF_FFFC);
        g_wait = 3;
        tick();
        chk("wrap_addr", Mem_Addr_o, 32'h0000_0000);
        chk("wrap_req", 32'(Mem_Req_o), 32'd1);

        // Reset mid-request, then while valid and stalled.
        rst = 1'b1;
        tick();
        chk("rstreq_req", 32'(Mem_Req_o), 32'd0);
        chk("rstreq_addr", Mem_Addr_o, RESET_PC);
        rst = 1'b0; stall = 1'b1;
        wait_valid(20);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("rststall_valid", 32'(Instr_Valid_o), 32'd0);
        chk("rststall_ipc", Instr_PC_o, 32'd0);
        rst = 1'b0; stall = 1'b0;
        tick();
        chk("restart_addr", Mem_Addr_o, RESET_PC);

        // Misaligned redirect with a request in flight.
        g_wait = 2;
        redir = 1'b1; rpc = 32'h0040_0102;
        tick();
        chk("mis_fault", 32'(Fault_o), 32'd1);
        chk("mis_req", 32'(Mem_Req_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("fault_hold", 32'(Fault_o), 32'd1);
        end
        redir = 1'b1; rpc = RESET_PC;
        tick();
        chk("fault_ignore", 32'(Mem_Req_o), 32'd0);
        rst = 1'b1;
        tick();
        chk("fault_clr", 32'(Fault_o), 32'd0);
        rst = 1'b0;

        // Randomized traffic, aligned redirects only.
        g_wait = -1; g_stall_pct = 30; g_redir_pct = 5; g_mis_pct = 0;
        repeat (1500) tick();

        // Randomized traffic including misaligned redirects and recovery by reset.
        g_redir_pct = 8; g_mis_pct = 5;
        for (int i = 0; i < 1500; i++) begin
            rst = (Fault_o && $urandom_range(7, 0) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

- Producer side of the instruction bus: owns the PC and fetches 32-bit words from instruction memory over a req/ack handshake.
- Presents each word with its PC and a valid flag to decode; OP_o feeds the control unit's opcode input.
- Supports decode back-pressure (stall), branch/jump redirect and misaligned-target fault.
- One outstanding memory request; intended for the multi-cycle / wait-state memory variants of the core.

## Interface

- RESET_PC, 32'h0040_0000, PC fetched first after reset (word-aligned)
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- Mem_Req_o  out  1  fetch request, held high until acknowledged
- Mem_Addr_o  out  32  fetch address, stable while Mem_Req_o=1
- Mem_Ack_i  in  1  one-cycle pulse, Mem_Data_i valid in same cycle; ignored when Mem_Req_o=0
- Mem_Data_i  in  32  instruction word
- Stall_i  in  1  decode not ready; held word must not change
- Redirect_i  in  1  one-cycle pulse: restart fetch at Redirect_PC_i
- Redirect_PC_i  in  32  redirect target
- Instr_o  out  32  fetched instruction
- Instr_PC_o  out  32  address of Instr_o
- Instr_Valid_o  out  1  Instr_o/Instr_PC_o valid
- OP_o  out  7  Instr_o[6:0]
- Fault_o  out  1  sticky misaligned-redirect flag

## Operation

- States: REQ, VALID, FAULT. Internal: pc (32), discard (1).
- Reset (any state, any cycle, overrides all inputs): state=REQ, pc=RESET_PC, discard=0; outputs Mem_Req_o=0, Mem_Addr_o=RESET_PC, Instr_o=32'h0000_0013 (NOP), OP_o=7'h13, Instr_PC_o=0, Instr_Valid_o=0, Fault_o=0.
- Mem_Req_o = (state==REQ) and not in reset cycle; Mem_Addr_o = pc.
- REQ, Mem_Ack_i=1, discard=0: Instr_o<=Mem_Data_i, Instr_PC_o<=pc, pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0), state<=VALID.
- REQ, Mem_Ack_i=1, discard=1: data dropped, discard<=0, stay REQ (pc already holds target).
- VALID: Instr_Valid_o=1. Consume = Instr_Valid_o & ~Stall_i; on consume, state<=REQ. While Stall_i=1, all outputs hold.
- Redirect_i=1 with Redirect_PC_i[1:0]==0:
  - In REQ: pc<=target. Discard<=1 unless Mem_Ack_i is high the same cycle (that word is dropped immediately). Mem_Addr_o changes only after an ack, so the in-flight request is never altered.
  - In VALID: pc<=target, state<=REQ, Instr_Valid_o<=0 next cycle, regardless of Stall_i. Redirect beats consume.
- Redirect_i=1 with Redirect_PC_i[1:0]!=0: state<=FAULT.
  - If a request is in flight, it is abandoned (Mem_Req_o drops); memory must tolerate this.
  - FAULT: Fault_o=1, Mem_Req_o=0, Instr_Valid_o=0; exit only by reset.
- Redirect_i while in FAULT: ignored.

## Timing

- Mem_Req_o first rises on the cycle after reset is sampled low.
- Ack may arrive in the first cycle Mem_Req_o is high (zero wait) or any later cycle; N wait cycles add N cycles.
- Ack in cycle t -> Instr_Valid_o=1 in t+1. Consume in cycle t+1 -> Mem_Req_o=1 in t+2.
- Peak throughput: one instruction per 2 cycles with zero-wait memory.
- Redirect in VALID in cycle t -> Mem_Req_o=1 with Mem_Addr_o=target in t+1.
- Redirect in REQ -> target request starts the cycle after the pending ack.
- Misaligned redirect in t -> Fault_o=1, Mem_Req_o=0 in t+1.
- Outputs are registered or decoded from state only; no input-to-output combinational path.

## Test plan

- Reset release, zero-wait memory returning 0x00500093, 0x00A00113: Mem_Addr_o=0x00400000 then 0x00400004. Instr_Valid_o high every other cycle. Instr_PC_o matches. OP_o=0x13.
- 3-cycle wait states: Mem_Req_o/Mem_Addr_o stable for 4 cycles. Instr_Valid_o rises the cycle after the ack. No second request before consume.
- Stall_i=1 for 5 cycles while VALID: Instr_o, Instr_PC_o, Instr_Valid_o unchanged. Next request the cycle after Stall_i falls.
- Redirect to 0x00400100 during 2-wait REQ: the old ack's data never appears as valid. Next request address is 0x00400100. Same-cycle ack+redirect also drops the word.
- Redirect to 0x00400102: Fault_o=1 and Mem_Req_o=0 the next cycle. Both hold for 10 cycles. Reset clears to the reset values.
- Reset asserted mid-request and while VALID+stalled: outputs return to reset values the next cycle. Fetch restarts at RESET_PC. PC wrap: redirect to 0xFFFFFFFC, consume -> next address 0x00000000.
